// File: rtl/pipe_pkg.sv
// Shared pipeline types: widths, ALU opcodes, ID/EX state and control bundle.
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [ALU_OP_W-1:0] alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard, writeback bypass and held-operand snoop selects.
module hazard_detect #(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_read1,
    input  logic [REG_AW-1:0] ex_read2,
    input  logic              id_valid,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_read1,
    input  logic [REG_AW-1:0] id_read2,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    output logic              hz,
    output logic              byp1,
    output logic              byp2,
    output logic              snp1,
    output logic              snp2
);

    logic dep1;
    logic dep2;

    // r0 is an ordinary register here, so no index is excluded
    assign dep1 = id_use1 && (id_read1 == ex_rd);
    assign dep2 = id_use2 && (id_read2 == ex_rd);
    assign hz   = ex_valid && ex_mem_read && id_valid && (dep1 || dep2);

    assign byp1 = wb_reg_write && (wb_write_reg == id_read1);
    assign byp2 = wb_reg_write && (wb_write_reg == id_read2);
    assign snp1 = wb_reg_write && (wb_write_reg == ex_read1);
    assign snp2 = wb_reg_write && (wb_write_reg == ex_read2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use bubble, flush and hold.
// HAZARD_STALL_CNT_EN adds a 32-bit count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int DATA_W   = pipe_pkg::DATA_W,
    parameter int REG_AW   = pipe_pkg::REG_AW,
    parameter int ALU_OP_W = pipe_pkg::ALU_OP_W
) (
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]         stall_cnt,
`endif
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [REG_AW-1:0]   id_read1,
    input  logic [REG_AW-1:0]   id_read2,
    input  logic                id_use1,
    input  logic                id_use2,
    input  logic [DATA_W-1:0]   id_data1,
    input  logic [DATA_W-1:0]   id_data2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_write_reg,
    input  logic [DATA_W-1:0]   wb_write_data,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_data1,
    output logic [DATA_W-1:0]   ex_data2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [REG_AW-1:0]   ex_read1,
    output logic [REG_AW-1:0]   ex_read2,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic [ALU_OP_W-1:0] ex_alu_op
);

    import pipe_pkg::*;

    state_e      state_q;
    state_e      state_d;
    id_ex_ctrl_t ctrl_q;
    id_ex_ctrl_t id_ctrl;

    logic hold;
    logic hz;
    logic byp1;
    logic byp2;
    logic snp1;
    logic snp2;

    assign hold = ex_valid && !ex_ready;

    hazard_detect #(
        .REG_AW(REG_AW)
    ) u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (ex_rd),
        .ex_read1    (ex_read1),
        .ex_read2    (ex_read2),
        .id_valid    (id_valid),
        .id_use1     (id_use1),
        .id_use2     (id_use2),
        .id_read1    (id_read1),
        .id_read2    (id_read2),
        .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg),
        .hz          (hz),
        .byp1        (byp1),
        .byp2        (byp2),
        .snp1        (snp1),
        .snp2        (snp2)
    );

    assign id_ctrl.reg_write = id_reg_write;
    assign id_ctrl.mem_read  = id_mem_read;
    assign id_ctrl.mem_write = id_mem_write;
    assign id_ctrl.alu_op    = id_alu_op;

    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_alu_op    = ctrl_q.alu_op;

    always_comb begin
        state_d  = state_q;
        id_ready = rst_n && (flush || (!hold && !hz));
        unique case (state_q)
            RUN: begin
                if (!flush && !hold && hz) begin
                    state_d = BUBBLE;
                end
            end
            BUBBLE: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_read1 <= '0;
            ex_read2 <= '0;
            ex_rd    <= '0;
            ctrl_q   <= '0;
        end else if (flush) begin
            ex_valid         <= 1'b0;
            ctrl_q.reg_write <= 1'b0;
            ctrl_q.mem_read  <= 1'b0;
            ctrl_q.mem_write <= 1'b0;
        end else if (hold) begin
            // WB lands while EX stalls: keep the held operands current
            if (snp1) ex_data1 <= wb_write_data;
            if (snp2) ex_data2 <= wb_write_data;
        end else if (hz) begin
            ex_valid         <= 1'b0;
            ctrl_q.reg_write <= 1'b0;
            ctrl_q.mem_read  <= 1'b0;
            ctrl_q.mem_write <= 1'b0;
        end else begin
            ex_valid <= id_valid;
            if (id_valid) begin
                ex_data1 <= byp1 ? wb_write_data : id_data1;
                ex_data2 <= byp2 ? wb_write_data : id_data2;
                ex_imm   <= id_imm;
                ex_read1 <= id_read1;
                ex_read2 <= id_read2;
                ex_rd    <= id_rd;
                ctrl_q   <= id_ctrl;
            end else begin
                ctrl_q.reg_write <= 1'b0;
                ctrl_q.mem_read  <= 1'b0;
                ctrl_q.mem_write <= 1'b0;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!flush && !hold && hz) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: bypass, load-use, snoop, flush, reset.
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [3:0]  op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_read1;
    logic [4:0]  id_read2;
    logic        id_use1;
    logic        id_use2;
    logic [31:0] id_data1;
    logic [31:0] id_data2;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic [3:0]  id_alu_op;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_read1;
    logic [4:0]  ex_read2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [3:0]  ex_alu_op;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int   tests = 0;
    int   failed = 0;
    exp_t sbq[$];
    exp_t last;
    exp_t e;
    exp_t obs;

    always #5 clk = ~clk;

    id_ex_stage dut (
`ifdef HAZARD_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_read1     (id_read1),
        .id_read2     (id_read2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .id_data1     (id_data1),
        .id_data2     (id_data2),
        .id_imm       (id_imm),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_alu_op    (id_alu_op),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_data1     (ex_data1),
        .ex_data2     (ex_data2),
        .ex_imm       (ex_imm),
        .ex_read1     (ex_read1),
        .ex_read2     (ex_read2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_alu_op    (ex_alu_op)
    );

    function automatic exp_t observe();
        exp_t o;
        o.v   = ex_valid;
        o.d1  = ex_data1;
        o.d2  = ex_data2;
        o.imm = ex_imm;
        o.r1  = ex_read1;
        o.r2  = ex_read2;
        o.rd  = ex_rd;
        o.rw  = ex_reg_write;
        o.mr  = ex_mem_read;
        o.mw  = ex_mem_write;
        o.op  = ex_alu_op;
        return o;
    endfunction

    task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [3:0] op);
        id_valid     = v;
        id_read1     = r1;
        id_use1      = u1;
        id_read2     = r2;
        id_use2      = u2;
        id_data1     = d1;
        id_data2     = d2;
        id_imm       = imm;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
        id_alu_op    = op;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write  = en;
        wb_write_reg  = r;
        wb_write_data = d;
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] imm,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic rw,
                                input logic mr, input logic mw,
                                input logic [3:0] op);
        exp_t x;
        x = '{v, d1, d2, imm, r1, r2, rd, rw, mr, mw, op};
        return x;
    endfunction

    task automatic push(input exp_t x);
        sbq.push_back(x);
        last = x;
    endtask

    function automatic exp_t inert(input exp_t x);
        exp_t y;
        y    = x;
        y.v  = 1'b0;
        y.rw = 1'b0;
        y.mr = 1'b0;
        y.mw = 1'b0;
        return y;
    endfunction

    task automatic edge_pop(output exp_t ex, output exp_t ob);
        @(posedge clk);
        #1;
        ob = observe();
        if (sbq.size() == 0) begin
            ex = '0;
            ex.v = 1'bx;
        end else begin
            ex = sbq.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_id_ready got=%b exp=0", id_ready);
        end
        push('0);
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, e);
        end
`ifdef HAZARD_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd0) begin
            failed++;
            $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drv(1, 5'd1, 1, 5'd3, 1, 32'd10, 32'd1, 32'h100, 5'd2, 1, 0, 0, 4'd1);
        wb(1, 5'd3, 32'h55);
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            failed++;
            $display("FAIL bypass_id_ready got=%b exp=1", id_ready);
        end
        push(mk(1, 32'd10, 32'h55, 32'h100, 5'd1, 5'd3, 5'd2, 1, 0, 0, 4'd1));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL bypass_capture got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        drv(1, 5'd0, 1, 5'd0, 1, 32'd0, 32'd0, 32'h5, 5'd4, 0, 0, 1, 4'd2);
        wb(1, 5'd0, 32'd7);
        push(mk(1, 32'd7, 32'd7, 32'h5, 5'd0, 5'd0, 5'd4, 0, 0, 1, 4'd2));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL reg0_bypass got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        drv(0, 5'd9, 0, 5'd9, 0, 32'hDEAD, 32'hBEEF, 32'h9, 5'd9, 1, 1, 1, 4'd9);
        wb(0, 5'd0, 32'd0);
        push(inert(last));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL idle_inert got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_load_use();
        exp_t lw;
        @(negedge clk);
        drv(1, 5'd5, 1, 5'd0, 0, 32'h1000, 32'h0, 32'h4, 5'd7, 1, 1, 0, 4'd0);
        lw = mk(1, 32'h1000, 32'h0, 32'h4, 5'd5, 5'd0, 5'd7, 1, 1, 0, 4'd0);
        push(lw);
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL lu_load got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        drv(1, 5'd7, 1, 5'd8, 1, 32'h11, 32'h22, 32'h0, 5'd9, 1, 0, 0, 4'd3);
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            failed++;
            $display("FAIL lu_stall_ready got=%b exp=0", id_ready);
        end
        push(inert(lw));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL lu_bubble got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        wb(1, 5'd7, 32'h77);
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            failed++;
            $display("FAIL lu_resume_ready got=%b exp=1", id_ready);
        end
        push(mk(1, 32'h77, 32'h22, 32'h0, 5'd7, 5'd8, 5'd9, 1, 0, 0, 4'd3));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL lu_dependent got=%h exp=%h", obs, e);
        end
`ifdef HAZARD_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd1) begin
            failed++;
            $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt);
        end
`endif
        @(negedge clk);
        wb(0, 5'd0, 32'd0);
    endtask

    task automatic test_hold_snoop();
        exp_t h;
        drv(1, 5'd1, 1, 5'd2, 1, 32'h1, 32'h2, 32'h3, 5'd10, 1, 0, 0, 4'd2);
        h = mk(1, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd10, 1, 0, 0, 4'd2);
        push(h);
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL hold_capture got=%h exp=%h", obs, e);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_ready = 1'b0;
            drv(1, 5'd4, 1, 5'd5, 1, 32'h44, 32'h45, 32'h6, 5'd11, 0, 0, 1, 4'd4);
            if (c == 1) wb(1, 5'd1, 32'hAB);
            else wb(0, 5'd0, 32'd0);
            #1;
            tests++;
            if (id_ready !== 1'b0) begin
                failed++;
                $display("FAIL hold_id_ready c=%0d got=%b exp=0", c, id_ready);
            end
            if (c == 1) h.d1 = 32'hAB;
            push(h);
            edge_pop(e, obs);
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL hold_snoop c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        @(negedge clk);
        ex_ready = 1'b1;
        push(mk(1, 32'h44, 32'h45, 32'h6, 5'd4, 5'd5, 5'd11, 0, 0, 1, 4'd4));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL hold_release got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_flush_bubble();
        exp_t lw;
        @(negedge clk);
        drv(1, 5'd6, 1, 5'd0, 0, 32'h2000, 32'h0, 32'h8, 5'd7, 1, 1, 0, 4'd0);
        lw = mk(1, 32'h2000, 32'h0, 32'h8, 5'd6, 5'd0, 5'd7, 1, 1, 0, 4'd0);
        push(lw);
        edge_pop(e, obs);
        @(negedge clk);
        drv(1, 5'd3, 0, 5'd7, 1, 32'h33, 32'h34, 32'h0, 5'd12, 1, 0, 0, 4'd1);
        push(inert(lw));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL fl_bubble got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            failed++;
            $display("FAIL fl_id_ready got=%b exp=1", id_ready);
        end
        push(inert(lw));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL fl_flush got=%h exp=%h", obs, e);
        end
        @(negedge clk);
        flush    = 1'b0;
        id_valid = 1'b0;
        push(inert(lw));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL fl_dropped got=%h exp=%h", obs, e);
        end
`ifdef HAZARD_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd2) begin
            failed++;
            $display("FAIL fl_stall_cnt got=%0d exp=2", stall_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        drv(1, 5'd2, 1, 5'd3, 1, 32'hA, 32'hB, 32'hC, 5'd13, 1, 0, 0, 4'd5);
        push(mk(1, 32'hA, 32'hB, 32'hC, 5'd2, 5'd3, 5'd13, 1, 0, 0, 4'd5));
        edge_pop(e, obs);
        @(negedge clk);
        ex_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            failed++;
            $display("FAIL rmh_id_ready got=%b exp=0", id_ready);
        end
        push('0);
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL rmh_zero got=%h exp=%h", obs, e);
        end
`ifdef HAZARD_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd0) begin
            failed++;
            $display("FAIL rmh_stall_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n    = 1'b1;
        ex_ready = 1'b1;
        drv(1, 5'd14, 1, 5'd15, 0, 32'hE, 32'hF, 32'h10, 5'd16, 0, 0, 1, 4'd6);
        push(mk(1, 32'hE, 32'hF, 32'h10, 5'd14, 5'd15, 5'd16, 0, 0, 1, 4'd6));
        edge_pop(e, obs);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL rmh_resume got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, imm;
        logic [4:0]  r1, r2, rd;
        logic [3:0]  op;
        logic        rw, mw;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d1  = $urandom;
            d2  = $urandom;
            imm = $urandom;
            r1  = 5'($urandom_range(0, 31));
            r2  = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            op  = 4'($urandom_range(0, 9));
            rw  = 1'($urandom_range(0, 1));
            mw  = 1'($urandom_range(0, 1));
            drv(1, r1, 1, r2, 1, d1, d2, imm, rd, rw, 0, mw, op);
            #1;
            tests++;
            if (id_ready !== 1'b1) begin
                failed++;
                $display("FAIL b2b_ready i=%0d got=%b exp=1", i, id_ready);
            end
            push(mk(1, d1, d2, imm, r1, r2, rd, rw, 0, mw, op));
            edge_pop(e, obs);
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL b2b i=%0d got=%h exp=%h", i, obs, e);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        drv(0, 5'd0, 0, 5'd0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 4'd0);
        wb(0, 5'd0, 32'd0);
        test_reset();
        test_bypass();
        test_load_use();
        test_hold_snoop();
        test_flush_bubble();
        test_reset_mid_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage pipeline, sitting directly downstream of the register file. It captures the two register-file read values plus decoded control for one instruction per cycle and presents them to EX. It bypasses same-cycle writeback data, because the register file writes on the clock edge and its reads are combinational. It detects load-use hazards, inserting one bubble and back-pressuring ID, and supports flush and EX back-pressure.

## Interface
- DATA_W, 32, register/immediate width
- REG_AW, 5, register index width
- ALU_OP_W, 4, ALU opcode width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard ID input and EX-held instruction
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage accepts the ID instruction this cycle (combinational)
- id_read1 / id_read2  in  REG_AW  source register indices (same as register-file read1/read2)
- id_use1 / id_use2  in  1  source actually used by the instruction
- id_data1 / id_data2  in  DATA_W  register-file data1/data2
- id_imm  in  DATA_W  sign-extended immediate
- id_rd  in  REG_AW  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  control
- id_alu_op  in  ALU_OP_W  ALU opcode
- wb_reg_write  in  1  writeback enable (same signal as register-file reg_write)
- wb_write_reg  in  REG_AW  writeback index
- wb_write_data  in  DATA_W  writeback data
- ex_ready  in  1  EX accepts the held instruction
- ex_valid  out  1  held instruction valid
- ex_data1 / ex_data2, ex_imm  out  DATA_W  operands
- ex_read1 / ex_read2, ex_rd  out  REG_AW  indices
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control
- ex_alu_op  out  ALU_OP_W

## Operation
- Register 0 is writable in this design. There is no zero-register special-casing in any comparison.
- Bypass: `bypN = wb_reg_write && wb_write_reg == id_readN`. The captured `ex_dataN` is `wb_write_data` if bypN, else `id_dataN`.
- Snoop: while holding, if `wb_reg_write && wb_write_reg == ex_readN`, then `ex_dataN <= wb_write_data`. Held operands never go stale.
- Load-use hazard:
  - `hz = ex_valid && ex_mem_read && id_valid && ((id_use1 && id_read1 == ex_rd) || (id_use2 && id_read2 == ex_rd))`.
- State machine, two states:
  - RUN: normal capture.
  - BUBBLE: entered when hz and EX advances. The outgoing slot is `ex_valid=0` for one cycle and the ID instruction is held (`id_ready=0`). Returns to RUN on the next edge unconditionally.
- Per-edge priority, highest first:
  1. !rst_n: all outputs 0, state RUN.
  2. flush: `ex_valid<=0`, state RUN. `id_ready=1`, so the ID instruction is consumed and dropped.
  3. Hold (`ex_valid && !ex_ready`): registers unchanged except snoop. `id_ready=0`.
  4. hz: `ex_valid<=0` (bubble), state BUBBLE. `id_ready=0`.
  5. Capture: `ex_valid<=id_valid`. When id_valid, all ex_* fields are loaded. `id_ready=1`.
- When `ex_valid<=0`, the data fields keep their old values. Control outputs `ex_reg_write/ex_mem_read/ex_mem_write` are forced to 0 so a bubble is inert.

## Timing
- Latency: 1 cycle, ID accept to ex_valid.
- Throughput: 1 instruction/cycle without hazard. A load-use costs exactly 1 bubble cycle.
- id_ready depends combinationally on flush, ex_ready, and hz. It has no path from id_data*.
- Reset values: every output 0, including ex_valid, id_ready (while !rst_n), and all data/control.
- Reset mid-stall returns the stage to RUN with no pending instruction.
- Simultaneous hold plus WB write to a held source register: the snoop applies on that edge.
- Simultaneous bypass and capture: the bypassed value wins over id_data.
- flush during BUBBLE: exit to RUN. The ID instruction is dropped.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - adds output `stall_cnt` (32 bits), reset 0.
  - increments on every edge where a load-use bubble is inserted.
  - wraps 0xFFFFFFFF→0.
  - flush and hold cycles are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- The shared package `pipe_pkg` holds:
  - DATA_W, REG_AW, ALU_OP_W defaults.
  - The ALU opcode enum.
  - The state enum {RUN, BUBBLE}.
  - A packed `id_ex_ctrl_t` struct {reg_write, mem_read, mem_write, alu_op}.
- One sub-module, `hazard_detect`: combinational hz and bypass-select logic. The stage itself owns all flops.

## Test plan
- Capture with bypass: ID r1 plus r3 with id_data1=10, id_data2=1, and the same cycle WB writes r3=0x55 → next cycle ex_valid=1, ex_data1=10, ex_data2=0x55.
- Load-use: EX holds lw r7 (ex_mem_read=1, ex_rd=7), ID uses r7 → id_ready=0 one cycle, one bubble (ex_valid=0, controls 0), then the dependent instruction is captured. With HAZARD_STALL_CNT_EN, stall_cnt=1.
- Hold plus snoop: ex_ready=0 for 3 cycles with ex_read1=1; WB writes r1=0xAB in cycle 2 → ex_data1=0xAB when released, and id_ready=0 throughout.
- Flush in BUBBLE: hz cycle, then flush=1 → ex_valid=0, state RUN, ID instruction dropped (id_ready=1).
- Reset mid-hold: rst_n=0 one cycle while ex_valid=1 and ex_ready=0 → all outputs 0 next cycle, and capture resumes normally afterward.
- Register 0 path: WB writes r0=7 while ID reads r0 → ex_data1=7 (no zero hardwiring).
